// File: rtl/gpio_pkg.sv
// Shared constants for the APB GPIO responder: register indices, pad mode
// encoding and the bus-side state type.
package gpio_pkg;

  localparam logic [31:0] REG_MODE      = 32'd0;
  localparam logic [31:0] REG_DIRECTION = 32'd1;
  localparam logic [31:0] REG_OUTPUT    = 32'd2;
  localparam logic [31:0] REG_INPUT     = 32'd3;
  localparam logic [31:0] REG_TR_TYPE   = 32'd4;
  localparam logic [31:0] REG_TR_LVL0   = 32'd5;
  localparam logic [31:0] REG_TR_LVL1   = 32'd6;
  localparam logic [31:0] REG_TR_STAT   = 32'd7;
  localparam logic [31:0] REG_IRQ_EN    = 32'd8;

  localparam logic MODE_PUSH_PULL  = 1'b0;
  localparam logic MODE_OPEN_DRAIN = 1'b1;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser bringing asynchronous pad inputs into the CLK domain.
module gpio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < int'(STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/apb_gpio_responder.sv
// APB3 completer holding the GPIO register file, pad drivers, trigger
// detection with sticky W1C status, and the level interrupt output.
module apb_gpio_responder
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_PINS  = 32,
  parameter int unsigned PADDR_SIZE = 4,
  parameter int unsigned STAGES     = 2
) (
  input  logic                   CLK,
  input  logic                   HRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic [PADDR_SIZE-1:0]  PADDR,
  input  logic                   PWRITE,
  input  logic [GPIO_PINS-1:0]   PWDATA,
  input  logic [GPIO_PINS/8-1:0] PSTRB,
  output logic                   PREADY,
  output logic [GPIO_PINS-1:0]   PRDATA,
  output logic                   PSLVERR,
  output logic                   irq_o,
  input  logic [GPIO_PINS-1:0]   gpio_i,
  output logic [GPIO_PINS-1:0]   gpio_o,
  output logic [GPIO_PINS-1:0]   gpio_oe
);

  typedef logic [GPIO_PINS-1:0] word_t;

  apb_state_e            state_q, state_d;
  logic [PADDR_SIZE-1:0] addr_q, addr_d;
  word_t mode_q, mode_d, dir_q, dir_d, out_q, out_d;
  word_t type_q, type_d, lvl0_q, lvl0_d, lvl1_q, lvl1_d;
  word_t stat_q, stat_d, irqen_q, irqen_d;
  word_t prev_q, prdata_q, prdata_d, pad_o_q, pad_o_d, pad_oe_q, pad_oe_d;
  logic  irq_q, irq_d;

  word_t in_sync, wmask, hit, clr, rd_data;
  logic  setup, access, addr_err, wr;

  gpio_sync #(.WIDTH(GPIO_PINS), .STAGES(STAGES)) u_sync (
    .clk_i  (CLK),
    .rst_ni (HRESETn),
    .d_i    (gpio_i),
    .q_o    (in_sync)
  );

  function automatic word_t merge(word_t old_v, word_t new_v, word_t m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // An access phase only counts when it directly follows a setup phase.
  assign setup    = PSEL & ~PENABLE;
  assign access   = PSEL & PENABLE & (state_q == APB_SETUP);
  assign addr_err = 32'(addr_q) > REG_IRQ_EN;
  assign wr       = access & PWRITE & ~addr_err;

  always_comb begin
    rd_data = '0;
    case (32'(PADDR))
      REG_MODE:      rd_data = mode_q;
      REG_DIRECTION: rd_data = dir_q;
      REG_OUTPUT:    rd_data = out_q;
      REG_INPUT:     rd_data = in_sync;
      REG_TR_TYPE:   rd_data = type_q;
      REG_TR_LVL0:   rd_data = lvl0_q;
      REG_TR_LVL1:   rd_data = lvl1_q;
      REG_TR_STAT:   rd_data = stat_q;
      REG_IRQ_EN:    rd_data = irqen_q;
      default:       rd_data = '0;
    endcase
  end

  always_comb begin
    state_d  = APB_IDLE;
    addr_d   = addr_q;
    prdata_d = prdata_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    out_d    = out_q;
    type_d   = type_q;
    lvl0_d   = lvl0_q;
    lvl1_d   = lvl1_q;
    irqen_d  = irqen_q;
    clr      = '0;
    wmask    = '0;
    pad_o_d  = '0;
    pad_oe_d = '0;

    if (setup) begin
      state_d  = APB_SETUP;
      addr_d   = PADDR;
      prdata_d = rd_data;
    end else if (access) begin
      state_d = APB_ACCESS;
    end

    for (int b = 0; b < int'(GPIO_PINS/8); b++) wmask[b*8 +: 8] = {8{PSTRB[b]}};

    if (wr) begin
      case (32'(addr_q))
        REG_MODE:      mode_d  = merge(mode_q,  PWDATA, wmask);
        REG_DIRECTION: dir_d   = merge(dir_q,   PWDATA, wmask);
        REG_OUTPUT:    out_d   = merge(out_q,   PWDATA, wmask);
        REG_TR_TYPE:   type_d  = merge(type_q,  PWDATA, wmask);
        REG_TR_LVL0:   lvl0_d  = merge(lvl0_q,  PWDATA, wmask);
        REG_TR_LVL1:   lvl1_d  = merge(lvl1_q,  PWDATA, wmask);
        REG_TR_STAT:   clr     = PWDATA & wmask;
        REG_IRQ_EN:    irqen_d = merge(irqen_q, PWDATA, wmask);
        default:       ;
      endcase
    end

    hit = (type_q  & ((lvl1_q & in_sync & ~prev_q) | (lvl0_q & ~in_sync & prev_q)))
        | (~type_q & ((lvl1_q & in_sync) | (lvl0_q & ~in_sync)));
    // A new hit takes priority over a simultaneous clear.
    stat_d = hit | (stat_q & ~clr);
    irq_d  = |(stat_q & irqen_q);

    for (int i = 0; i < int'(GPIO_PINS); i++) begin
      if (mode_q[i] == MODE_OPEN_DRAIN) begin
        pad_o_d[i]  = 1'b0;
        pad_oe_d[i] = dir_q[i] & ~out_q[i];
      end else begin
        pad_o_d[i]  = out_q[i];
        pad_oe_d[i] = dir_q[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= APB_IDLE;
      addr_q   <= '0;
      prdata_q <= '0;
      mode_q   <= '0;
      dir_q    <= '0;
      out_q    <= '0;
      type_q   <= '0;
      lvl0_q   <= '0;
      lvl1_q   <= '0;
      stat_q   <= '0;
      irqen_q  <= '0;
      prev_q   <= '0;
      pad_o_q  <= '0;
      pad_oe_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      prdata_q <= prdata_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      out_q    <= out_d;
      type_q   <= type_d;
      lvl0_q   <= lvl0_d;
      lvl1_q   <= lvl1_d;
      stat_q   <= stat_d;
      irqen_q  <= irqen_d;
      prev_q   <= in_sync;
      pad_o_q  <= pad_o_d;
      pad_oe_q <= pad_oe_d;
      irq_q    <= irq_d;
    end
  end

  assign PREADY  = 1'b1;
  assign PRDATA  = prdata_q;
  assign PSLVERR = access & addr_err;
  assign irq_o   = irq_q;
  assign gpio_o  = pad_o_q;
  assign gpio_oe = pad_oe_q;

endmodule

// File: tb/tb_apb_gpio_responder.sv
// Directed bench for apb_gpio_responder: register access, pads, triggers, errors.
module tb_apb_gpio_responder;

  logic        CLK = 1'b0;
  logic        HRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        irq_o;
  logic [31:0] gpio_i, gpio_o, gpio_oe;

  int pass_cnt = 0;
  int total_cnt = 0;

  apb_gpio_responder #(.GPIO_PINS(32), .PADDR_SIZE(4), .STAGES(2)) dut (
    .CLK     (CLK),
    .HRESETn (HRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .irq_o   (irq_o),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe)
  );

  always #5 CLK = ~CLK;

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic err);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    #1 begin d = PRDATA; err = PSLVERR; end
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    HRESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total_cnt++;
    if (gpio_oe !== 32'h0) $display("FAIL reset_gpio_oe got %h want 0", gpio_oe); else pass_cnt++;
    total_cnt++;
    if (gpio_o !== 32'h0) $display("FAIL reset_gpio_o got %h want 0", gpio_o); else pass_cnt++;
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL reset_irq got %b want 0", irq_o); else pass_cnt++;
    HRESETn = 1'b1;
    for (int r = 0; r <= 8; r++) begin
      apb_read(4'(r), d, e);
      total_cnt++;
      if (d !== 32'h0 || e !== 1'b0)
        $display("FAIL reset_read idx %0d got %h err %b want 0 err 0", r, d, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    logic e;
    apb_write(4'd1, 32'hFFFF_FFFF, 4'hF, e);
    apb_write(4'd1, 32'h0000_0000, 4'b0101, e);
    apb_read(4'd1, d, e);
    total_cnt++;
    if (d !== 32'hFF00_FF00) $display("FAIL strobe_dir got %h want ff00ff00", d); else pass_cnt++;
    apb_write(4'd2, 32'h0000_0088, 4'hF, e);
    @(posedge CLK); #1;
    total_cnt++;
    if (gpio_o !== 32'h0000_0088) $display("FAIL pp_gpio_o got %h want 00000088", gpio_o); else pass_cnt++;
    total_cnt++;
    if (gpio_oe !== 32'hFF00_FF00) $display("FAIL pp_gpio_oe got %h want ff00ff00", gpio_oe); else pass_cnt++;
  endtask

  task automatic test_open_drain();
    logic e;
    apb_write(4'd0, 32'hFFFF_FFFF, 4'hF, e);
    apb_write(4'd1, 32'hFFFF_FFFF, 4'hF, e);
    apb_write(4'd2, 32'h0000_00F0, 4'hF, e);
    @(posedge CLK); #1;
    total_cnt++;
    if (gpio_oe !== 32'hFFFF_FF0F) $display("FAIL od_gpio_oe got %h want ffffff0f", gpio_oe); else pass_cnt++;
    total_cnt++;
    if (gpio_o !== 32'h0) $display("FAIL od_gpio_o got %h want 0", gpio_o); else pass_cnt++;
  endtask

  task automatic test_rising_edge();
    logic [31:0] d;
    logic e;
    apb_write(4'd4, 32'h1, 4'hF, e);
    apb_write(4'd6, 32'h1, 4'hF, e);
    apb_write(4'd8, 32'h1, 4'hF, e);
    @(posedge CLK); #1;
    gpio_i[0] = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL edge_irq_early got %b want 0", irq_o); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL edge_irq_rise got %b want 1", irq_o); else pass_cnt++;
    apb_read(4'd7, d, e);
    total_cnt++;
    if (d !== 32'h1) $display("FAIL edge_stat got %h want 00000001", d); else pass_cnt++;
    apb_write(4'd7, 32'h1, 4'hF, e);
    @(posedge CLK); #1;
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL w1c_irq got %b want 0", irq_o); else pass_cnt++;
    apb_read(4'd7, d, e);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL w1c_stat got %h want 0", d); else pass_cnt++;
  endtask

  task automatic test_level_persist();
    logic [31:0] d;
    logic e;
    // pin0 is high with LVL1 set, pin1 low with LVL0 set: both are level hits.
    apb_write(4'd4, 32'h0, 4'hF, e);
    apb_write(4'd5, 32'h2, 4'hF, e);
    apb_write(4'd7, 32'h2, 4'hF, e);
    apb_read(4'd7, d, e);
    total_cnt++;
    if (d !== 32'h3) $display("FAIL level_persist got %h want 00000003", d); else pass_cnt++;
    gpio_i[1] = 1'b1;
    repeat (4) @(posedge CLK);
    apb_write(4'd7, 32'h2, 4'hF, e);
    apb_read(4'd7, d, e);
    total_cnt++;
    if (d !== 32'h1) $display("FAIL level_clear got %h want 00000001", d); else pass_cnt++;
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL level_irq got %b want 1", irq_o); else pass_cnt++;
  endtask

  task automatic test_error();
    logic [31:0] d;
    logic e;
    apb_write(4'd9, 32'h1234_5678, 4'hF, e);
    total_cnt++;
    if (e !== 1'b1) $display("FAIL err_write_pslverr got %b want 1", e); else pass_cnt++;
    apb_read(4'd9, d, e);
    total_cnt++;
    if (d !== 32'h0 || e !== 1'b1) $display("FAIL err_read got %h err %b want 0 err 1", d, e); else pass_cnt++;
    apb_read(4'd1, d, e);
    total_cnt++;
    if (d !== 32'hFFFF_FFFF || e !== 1'b0)
      $display("FAIL err_no_change got %h err %b want ffffffff err 0", d, e);
    else pass_cnt++;
    apb_write(4'd3, 32'hFFFF_FFFF, 4'hF, e);
    total_cnt++;
    if (e !== 1'b0) $display("FAIL input_write_err got %b want 0", e); else pass_cnt++;
    apb_read(4'd3, d, e);
    total_cnt++;
    if (d !== 32'h3) $display("FAIL input_read got %h want 00000003", d); else pass_cnt++;
  endtask

  task automatic test_penable_only();
    logic [31:0] d;
    logic e;
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 4'd8; PWDATA = 32'h0; PSTRB = 4'hF;
    #1;
    total_cnt++;
    if (PSLVERR !== 1'b0) $display("FAIL penable_only_err got %b want 0", PSLVERR); else pass_cnt++;
    repeat (2) @(posedge CLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_read(4'd8, d, e);
    total_cnt++;
    if (d !== 32'h1) $display("FAIL penable_only_irqen got %h want 00000001", d); else pass_cnt++;
  endtask

  initial begin
    HRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 4'h0; PWDATA = 32'h0; PSTRB = 4'h0;
    gpio_i = 32'h0;
    test_reset();
    test_strobes();
    test_open_drain();
    test_rising_edge();
    test_level_persist();
    test_error();
    test_penable_only();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
